// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned 16x16->32 shift-add multiplier.
// It owns no adder. Every iteration it borrows the shared 16-bit ALU through
// a request/grant handshake and issues one ADD. The pipeline can withhold the
// grant at any time, and the multiplier then simply waits.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_out,
    input  logic        alu_carry_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] ALU_OP_ADD  = 3'd2;
    localparam logic [2:0] ALU_OP_NONE = 3'd0;
    localparam logic [3:0] LAST_COUNT  = 4'd15;

    logic [1:0]  state_q,   state_d;
    logic [15:0] acc_hi_q,  acc_hi_d;
    logic [15:0] lo_q,      lo_d;
    logic [15:0] mcand_q,   mcand_d;
    logic [3:0]  count_q,   count_d;
    logic [31:0] product_q, product_d;
    logic        done_q,    done_d;
    logic        busy_q,    busy_d;

    // One shift-add step: the 17-bit ALU sum is shifted right by one.
    // Its bit 0 moves into the top of lo as the multiplier bits leave it.
    logic [15:0] step_acc_hi;
    logic [15:0] step_lo;

    // Drive the ALU request straight from the registered state. During a
    // stall the operands therefore stay stable.
    always_comb begin
        alu_req = (state_q == ST_STEP);
        alu_op  = alu_req ? ALU_OP_ADD : ALU_OP_NONE;
        alu_x   = alu_req ? acc_hi_q : 16'd0;
        alu_y   = (alu_req && lo_q[0]) ? mcand_q : 16'd0;
    end

    // Form the shifted accumulator and multiplier from the ALU result.
    always_comb begin
        step_acc_hi = {alu_carry_out, alu_out[15:1]};
        step_lo     = {alu_out[0], lo_q[15:1]};
    end

    // Next-state logic. The registers hold by default. A missing grant in
    // STEP therefore freezes the whole operation.
    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d     = a;
                    mcand_d  = b;
                    acc_hi_d = 16'd0;
                    count_d  = 4'd0;
                    state_d  = ST_STEP;
                end
            end
            ST_STEP: begin
                if (alu_gnt) begin
                    acc_hi_d = step_acc_hi;
                    lo_d     = step_lo;
                    count_d  = count_q + 4'd1;
                    if (count_q == LAST_COUNT) begin
                        product_d = {step_acc_hi, step_lo};
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with a synchronous active-low reset. Reset also
    // clears the result, so product reads zero after an aborted multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_hi_q  <= 16'd0;
            lo_q      <= 16'd0;
            mcand_q   <= 16'd0;
            count_q   <= 4'd0;
            product_q <= 32'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Status outputs come straight from flops, with no path from the ALU.
    always_comb begin
        busy    = busy_q;
        done    = done_q;
        product = product_q;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq, with a behavioural shared-ALU model. Product and
// latency come from plain arithmetic on the operands and the grant pattern.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        alu_req;
    logic        alu_gnt;
    logic [2:0]  alu_op;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_carry_out;

    int vectors;
    int miscompares;
    logic [31:0] last_prod;

    alu_mul_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .product(product),
        .alu_req(alu_req),
        .alu_gnt(alu_gnt),
        .alu_op(alu_op),
        .alu_x(alu_x),
        .alu_y(alu_y),
        .alu_out(alu_out),
        .alu_carry_out(alu_carry_out)
    );

    // Shared ALU: for op 2 it adds unsigned, with a carry out of bit 16.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum       = (alu_op == 3'd2) ? ({1'b0, alu_x} + {1'b0, alu_y}) : 17'd0;
        alu_out       = alu_sum[15:0];
        alu_carry_out = alu_sum[16];
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself loses its way.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a multiply in the current (IDLE) cycle and follow it cycle by
    // cycle until done. The task drives the grant in one of three patterns:
    // 0 = always granted, 1 = alternating with 0 first, 2 = random.
    // In each STEP cycle it predicts the ALU operands arithmetically.
    // After i accepted iterations, alu_x is (a[i-1:0]*b) >> i and alu_y is
    // b when a[i] is set. The task ends in the done cycle.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input int gnt_mode, input logic [31:0] hold_val,
                          output int done_cyc, output int exp_done_cyc,
                          output logic [31:0] prod, output int step_err,
                          output int busy_err, output int hold_err,
                          output int y_nz, output int stall_err);
        int grants;
        logic g;
        logic prev_stall;
        logic [15:0] prev_x;
        logic [15:0] prev_y;
        logic [31:0] mask;
        logic [31:0] partial;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        done_cyc     = -1;
        exp_done_cyc = -1;
        prod         = 32'hxxxxxxxx;
        step_err     = 0;
        busy_err     = 0;
        hold_err     = 0;
        y_nz         = 0;
        stall_err    = 0;
        grants       = 0;
        prev_stall   = 1'b0;
        prev_x       = 16'd0;
        prev_y       = 16'd0;
        a       = op_a;
        b       = op_b;
        start   = 1'b1;
        alu_gnt = 1'b1;
        tick();
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            case (gnt_mode)
                0:       g = 1'b1;
                1:       g = (cyc % 2 == 0);
                default: g = 1'($urandom_range(0, 1));
            endcase
            alu_gnt = g;
            if (done === 1'b1) begin
                done_cyc = cyc;
                prod     = product;
                if (alu_req !== 1'b0 || busy !== 1'b1) busy_err++;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            if (product !== hold_val) hold_err++;
            if (grants < 16) begin
                mask    = (32'd1 << grants) - 32'd1;
                partial = (({16'd0, op_a} & mask) * {16'd0, op_b}) >> grants;
                exp_x   = partial[15:0];
                exp_y   = op_a[grants] ? op_b : 16'd0;
                if (alu_req !== 1'b1 || alu_op !== 3'd2 ||
                    alu_x !== exp_x || alu_y !== exp_y) step_err++;
                if (alu_y !== 16'd0) y_nz++;
                if (prev_stall && (alu_x !== prev_x || alu_y !== prev_y)) stall_err++;
                prev_x     = alu_x;
                prev_y     = alu_y;
                prev_stall = !g;
                if (g) begin
                    grants++;
                    if (grants == 16) exp_done_cyc = cyc + 1;
                end
            end else begin
                step_err++;
            end
            tick();
        end
        alu_gnt = 1'b1;
    endtask

    // Right after reset every output must read zero.
    task automatic test_reset();
        vectors++;
        if ({busy, done, alu_req} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got busy/done/req=%b required 000", {busy, done, alu_req});
        end
        vectors++;
        if (product !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_product: got %h required 00000000", product);
        end
        vectors++;
        if (alu_op !== 3'd0 || alu_x !== 16'd0 || alu_y !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_alu: got op=%0d x=%h y=%h required all 0", alu_op, alu_x, alu_y);
        end
    endtask

    // Basic multiply 3*5 with the grant held high.
    task automatic test_basic();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        run_op(16'd3, 16'd5, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (dc !== 17 || dc !== edc) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got done cycle %0d required 17 (model %0d)", dc, edc);
        end
        vectors++;
        if (p !== 32'h0000000F) begin
            miscompares++;
            $display("[TB] FAIL basic_product: got %h required 0000000f", p);
        end
        vectors++;
        if (se != 0 || be != 0 || he != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_step: got step/busy/hold errors %0d/%0d/%0d required 0", se, be, he);
        end
        last_prod = 32'd15;
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || alu_req !== 1'b0 || product !== last_prod) begin
            miscompares++;
            $display("[TB] FAIL basic_after: got done=%b busy=%b req=%b prod=%h required 0 0 0 %h",
                     done, busy, alu_req, product, last_prod);
        end
    endtask

    // All-ones operands, so the ALU carry must feed acc_hi.
    task automatic test_carry();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        run_op(16'hFFFF, 16'hFFFF, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (p !== 32'hFFFE0001) begin
            miscompares++;
            $display("[TB] FAIL carry_product: got %h required fffe0001", p);
        end
        vectors++;
        if (se != 0 || dc !== edc) begin
            miscompares++;
            $display("[TB] FAIL carry_step: got step errors %0d done %0d required 0 and %0d", se, dc, edc);
        end
        last_prod = 32'hFFFE0001;
        tick();
    endtask

    // Alternating grant stretches the run and must not disturb the operands.
    task automatic test_stall();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        run_op(16'd1000, 16'd500, 1, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (dc !== 33 || dc !== edc) begin
            miscompares++;
            $display("[TB] FAIL stall_latency: got done cycle %0d required 33 (model %0d)", dc, edc);
        end
        vectors++;
        if (p !== 32'd500000) begin
            miscompares++;
            $display("[TB] FAIL stall_product: got %h required 0007a120", p);
        end
        vectors++;
        if (st != 0 || se != 0 || be != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_stable: got stall/step/busy errors %0d/%0d/%0d required 0", st, se, be);
        end
        last_prod = 32'd500000;
        tick();
    endtask

    // Zero operands: no non-zero addend, and a zero result.
    task automatic test_zero();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        run_op(16'd0, 16'h1234, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (yn != 0 || p !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_a: got %0d non-zero alu_y, product %h required 0 and 0", yn, p);
        end
        last_prod = 32'd0;
        tick();
        run_op(16'h1234, 16'd0, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (p !== 32'd0 || se != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_b: got product %h step errors %0d required 0 and 0", p, se);
        end
        tick();
    endtask

    // A second start mid-run is ignored, and reset aborts the operation.
    task automatic test_reset_mid();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        a       = 16'd7;
        b       = 16'd9;
        start   = 1'b1;
        alu_gnt = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        start = 1'b1;
        a     = 16'd1;
        b     = 16'd1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || alu_x !== 16'd1 || alu_y !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL ignore_start: got busy=%b x=%h y=%h required 1 0001 0000", busy, alu_x, alu_y);
        end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || product !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got busy=%b done=%b req=%b prod=%h required 0 0 0 0",
                     busy, done, alu_req, product);
        end
        rst_n     = 1'b1;
        last_prod = 32'd0;
        run_op(16'd2, 16'd3, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (p !== 32'd6 || dc !== 17) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got product %h at cycle %0d required 6 at 17", p, dc);
        end
        last_prod = 32'd6;
        tick();
    endtask

    // Start again in the first IDLE cycle. The old product holds until the
    // new done.
    task automatic test_back_to_back();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        logic [15:0] x1, y1, x2, y2;
        x1 = 16'($urandom);
        y1 = 16'($urandom);
        x2 = 16'($urandom);
        y2 = 16'($urandom);
        run_op(x1, y1, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (p !== x1 * y1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got %h required %h", p, 32'(x1) * 32'(y1));
        end
        last_prod = 32'(x1) * 32'(y1);
        tick();
        run_op(x2, y2, 0, last_prod, dc, edc, p, se, be, he, yn, st);
        vectors++;
        if (dc !== 17 || he != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got done rel cycle %0d hold errors %0d required 17 and 0", dc, he);
        end
        vectors++;
        if (p !== 32'(x2) * 32'(y2)) begin
            miscompares++;
            $display("[TB] FAIL b2b_product: got %h required %h", p, 32'(x2) * 32'(y2));
        end
        last_prod = 32'(x2) * 32'(y2);
        tick();
    endtask

    // Random operands with random grant stalls.
    task automatic test_random();
        int dc, edc, se, be, he, yn, st;
        logic [31:0] p;
        logic [15:0] ra, rb;
        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 2, last_prod, dc, edc, p, se, be, he, yn, st);
            vectors++;
            if (p !== 32'(ra) * 32'(rb) || dc !== edc) begin
                miscompares++;
                $display("[TB] FAIL random_op: a=%h b=%h got %h at %0d required %h at %0d",
                         ra, rb, p, dc, 32'(ra) * 32'(rb), edc);
            end
            vectors++;
            if (se != 0 || be != 0 || he != 0 || st != 0) begin
                miscompares++;
                $display("[TB] FAIL random_step: a=%h b=%h got errors %0d/%0d/%0d/%0d required 0",
                         ra, rb, se, be, he, st);
            end
            last_prod = 32'(ra) * 32'(rb);
            tick();
        end
    endtask

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        last_prod   = 32'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a           = 16'd0;
        b           = 16'd0;
        alu_gnt     = 1'b1;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_carry();
        test_stall();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 16x16->32 multiplier sequencer that borrows the shared 16-bit ALU instead of instantiating its own adder. It runs a shift-add algorithm, issuing one ADD (alu_op 2) per iteration. A request/grant handshake lets the pipeline keep priority on the ALU. It sits beside the execute stage and is started by the multiply instruction decode.

## Interface

Parameters: none. Width is fixed at 16 to match the ALU.

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- a  in  16  multiplier (unsigned), captured on accepted start
- b  in  16  multiplicand (unsigned), captured on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, product valid
- product  out  32  registered result; holds until next completion or reset
- alu_req  out  1  request for the shared ALU; high only in STEP
- alu_gnt  in  1  ALU granted this cycle; combinational result is consumed at the clock edge
- alu_op  out  3  2 (ADD) when alu_req, else 0
- alu_x  out  16  acc_hi when alu_req, else 0
- alu_y  out  16  lo[0] ? mcand : 0 when alu_req, else 0
- alu_out  in  16  ALU sum (combinational from alu_x/alu_y)
- alu_carry_out  in  1  ALU carry; bit 16 of the unsigned sum for op 2

## Operation

- Internal registers:
  - acc_hi[15:0]
  - lo[15:0] (multiplier, shifted out LSB-first)
  - mcand[15:0]
  - count[3:0]
  - state in {IDLE, STEP, DONE}
- IDLE:
  - start=1: lo<=a, mcand<=b, acc_hi<=0, count<=0, go to STEP.
  - start=0: stay in IDLE.
- STEP:
  - alu_req=1 and ALU outputs are driven as listed under Interface.
  - alu_gnt=0: nothing changes (stall). alu_op, alu_x and alu_y stay stable.
  - alu_gnt=1:
    - acc_hi <= {alu_carry_out, alu_out[15:1]}
    - lo <= {alu_out[0], lo[15:1]}
    - count <= count+1
  - alu_gnt=1 with count==15: go to DONE.
- DONE:
  - product <= {acc_hi, lo}, registered on the STEP->DONE edge so it is valid during DONE.
  - done=1 for exactly this cycle, then go to IDLE.
- An ADD is issued every iteration (y=0 when the multiplier bit is 0), so iteration timing is data-independent.
- ALU flags overflow/lt/eq/gt are ignored.
- start while busy (STEP or DONE) is ignored and has no effect on the running operation.
- Reset (rst_n=0 at a clock edge), from any state including mid-STEP:
  - state=IDLE
  - acc_hi, lo, mcand, count = 0
  - product = 0
  - done=0, busy=0, alu_req=0
- A stall in STEP freezes the operation indefinitely; there is no timeout.

## Timing

- Reset values of all outputs: busy=0, done=0, product=0, alu_req=0, alu_op=0, alu_x=0, alu_y=0.
- Cycle numbering: start is high in cycle 0 (state IDLE).
- With alu_gnt held high:
  - STEP occupies cycles 1-16.
  - DONE is cycle 17 (done=1, product valid).
  - IDLE is from cycle 18; a new start is accepted in cycle 18 at the earliest.
- Each cycle in STEP with alu_gnt=0 adds one cycle of latency: latency = 17 + stall cycles.
- busy is high in cycles 1 through 17 (plus stalls).
- alu_req goes high in cycle 1 and falls in the DONE cycle.
- All outputs are registered except alu_op, alu_x, alu_y and alu_req, which are combinational from registered state only. There is no combinational path from alu_gnt or alu_out to any output.

## Test plan

- a=3, b=5, gnt tied 1:
  - done pulses in cycle 17, product=0x0000000F.
  - busy high in cycles 1-17.
  - alu_op=2 in every STEP cycle.
- a=0xFFFF, b=0xFFFF, gnt=1:
  - product=0xFFFE0001 (exercises carry into acc_hi).
- a=1000, b=500, gnt alternating 0/1 starting at 0 in cycle 1:
  - done in cycle 33, product=0x0007A120 (500000).
  - alu_x and alu_y are unchanged across each stall cycle.
- a=0, b=0x1234:
  - alu_y=0 in all 16 STEP cycles, product=0.
  - Then a=0x1234, b=0: product=0.
- Start a=7, b=9; pulse start again in cycle 5 with a=1, b=1; assert rst_n=0 in cycle 8:
  - Second start is ignored.
  - Cycle 9: busy=0, done=0, alu_req=0, product=0.
  - A fresh start a=2, b=3 then gives product=6 seventeen cycles later.
- Back-to-back operations: start in cycle 18 after the first done.
  - Second operation completes in cycle 35.
  - product holds the first result in cycles 17-34.
